// File: rtl/fp_mul_finalize_if.sv
// Handshake and data bundle between the FP multiplier core, the finalize stage and the consumer.
// The master side drives operands and out_ready; the slave side (fp_mul_finalize) drives results.
interface fp_mul_finalize_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [9:0]  expSum;
    logic [47:0] product;
    logic        signal;
    logic        overflow;
    logic [31:0] specialResult;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        outOverflow;
    logic        underflow;

    modport master (
        output in_valid, sign, expSum, product, signal, overflow, specialResult, out_ready,
        input  in_ready, out_valid, result, outOverflow, underflow
    );

    modport slave (
        input  in_valid, sign, expSum, product, signal, overflow, specialResult, out_ready,
        output in_ready, out_valid, result, outOverflow, underflow
    );
endinterface

// File: rtl/fp_mul_finalize.sv
// Two-stage normalize / round-and-pack back end of a single-precision multiplier.
// Define FPM_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_mul_finalize (
    input  logic               clk,
    input  logic               rst,
    fp_mul_finalize_if.slave   bus
);
    // Stage 1 (normalize) registers
    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic [10:0]       s1_exp_reg;
    logic [22:0]       s1_mant_reg;
    logic              s1_guard_reg;
    logic              s1_sticky_reg;
    logic              s1_special_reg;
    logic              s1_special_nz_reg;

    // Stage 2 (output) registers
    logic              s2_valid_reg;
    logic [31:0]       result_reg;
    logic              ovf_reg;
    logic              unf_reg;

    logic              adv1;
    logic              adv2;

    // Stage 1 combinational normalize
    logic              norm_shift;
    logic [10:0]       exp_norm;
    logic [22:0]       mant_norm;
    logic              guard_norm;
    logic              sticky_norm;
    logic              special_nz;

    // Stage 2 combinational round/pack
    logic              round_up;
    logic [23:0]       mant_sum;
    logic [10:0]       exp_fin;
    logic [31:0]       result_next;
    logic              ovf_next;
    logic              unf_next;

    // The detector's overflow flag is redundant with specialResult, so it is not consumed.
    logic              unused_inputs;
    assign unused_inputs = bus.overflow;

    assign adv2         = !s2_valid_reg || bus.out_ready;
    assign adv1         = !s1_valid_reg || adv2;
    assign bus.in_ready = adv1 && !rst;

    assign bus.out_valid   = s2_valid_reg;
    assign bus.result      = result_reg;
    assign bus.outOverflow = ovf_reg;
    assign bus.underflow   = unf_reg;

    always_comb begin
        norm_shift  = bus.product[47];
        exp_norm    = {bus.expSum[9], bus.expSum} + {10'd0, norm_shift};
        mant_norm   = norm_shift ? bus.product[46:24] : bus.product[45:23];
        guard_norm  = norm_shift ? bus.product[23]    : bus.product[22];
        sticky_norm = norm_shift ? (|bus.product[22:0]) : (|bus.product[21:0]);
        // Case inequality so that an undriven/unknown special result still reads as non-zero.
        special_nz  = (bus.specialResult !== 32'd0);
    end

`ifdef FPM_ROUND_NEAREST_EN
    assign round_up = s1_guard_reg && (s1_sticky_reg || s1_mant_reg[0]);
`else
    logic unused_round;
    assign unused_round = s1_guard_reg ^ s1_sticky_reg;
    assign round_up     = 1'b0;
`endif

    always_comb begin
        // A carry out of an all-ones mantissa leaves mant_sum[22:0] at zero and bumps the exponent.
        mant_sum    = {1'b0, s1_mant_reg} + {23'd0, round_up};
        exp_fin     = s1_exp_reg + {10'd0, mant_sum[23]};
        result_next = {s1_sign_reg, exp_fin[7:0], mant_sum[22:0]};
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        if (s1_special_reg) begin
            if (s1_special_nz_reg) begin
                result_next = {s1_sign_reg, 8'hFF, 23'd0};
                ovf_next    = 1'b1;
            end else begin
                result_next = {s1_sign_reg, 31'd0};
                unf_next    = 1'b1;
            end
        end else if ($signed(exp_fin) >= 11'sd255) begin
            result_next = {s1_sign_reg, 8'hFF, 23'd0};
            ovf_next    = 1'b1;
        end else if ($signed(exp_fin) <= 11'sd0) begin
            result_next = {s1_sign_reg, 31'd0};
            unf_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg      <= 1'b0;
            s1_sign_reg       <= 1'b0;
            s1_exp_reg        <= 11'd0;
            s1_mant_reg       <= 23'd0;
            s1_guard_reg      <= 1'b0;
            s1_sticky_reg     <= 1'b0;
            s1_special_reg    <= 1'b0;
            s1_special_nz_reg <= 1'b0;
            s2_valid_reg      <= 1'b0;
            result_reg        <= 32'd0;
            ovf_reg           <= 1'b0;
            unf_reg           <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_reg       <= bus.sign;
                    s1_exp_reg        <= exp_norm;
                    s1_mant_reg       <= mant_norm;
                    s1_guard_reg      <= guard_norm;
                    s1_sticky_reg     <= sticky_norm;
                    s1_special_reg    <= bus.signal;
                    s1_special_nz_reg <= special_nz;
                end
            end
            // Output registers only change on advance, so they hold while the consumer stalls.
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    result_reg <= result_next;
                    ovf_reg    <= ovf_next;
                    unf_reg    <= unf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_finalize.sv
// Directed, table-driven checks of fp_mul_finalize plus streaming, backpressure and reset sequences.
// Build with or without FPM_ROUND_NEAREST_EN; expected rounding values follow the same macro.
module tb_fp_mul_finalize;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mul_finalize_if bus();

    fp_mul_finalize dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        sign;
        logic [9:0]  exp_sum;
        logic [47:0] product;
        logic        special;
        logic        ovf_in;
        logic [31:0] special_result;
        logic [31:0] exp_result;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input int i);
        bus.sign          = vec[i].sign;
        bus.expSum        = vec[i].exp_sum;
        bus.product       = vec[i].product;
        bus.signal        = vec[i].special;
        bus.overflow      = vec[i].ovf_in;
        bus.specialResult = vec[i].special_result;
    endtask

    task automatic apply_vec(input int i);
        @(negedge clk);
        drive(i);
        bus.in_valid = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check($sformatf("vec%0d early out_valid", i), 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'd1);
        check($sformatf("vec%0d result", i), 64'(bus.result), 64'(vec[i].exp_result));
        check($sformatf("vec%0d outOverflow", i), 64'(bus.outOverflow), 64'(vec[i].exp_ovf));
        check($sformatf("vec%0d underflow", i), 64'(bus.underflow), 64'(vec[i].exp_unf));
        $display("vec%0d: result=%h ovf=%0b unf=%0b", i, bus.result, bus.outOverflow, bus.underflow);
    endtask

    // Streams vectors 0..n-1, holding out_ready low for the first `stall` cycles.
    task automatic run_stream(input int n, input int stall);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int last_deq = -1;
        logic acc;
        logic held_v = 1'b0;
        logic [31:0] held_r = 32'd0;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            bus.out_ready = (cyc >= stall);
            if (sent < n) begin
                drive(sent);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                check("stall out_valid held", 64'(bus.out_valid), 64'd1);
                check("stall result held", 64'(bus.result), 64'(held_r));
                held_v = 1'b0;
            end
            if (stall > 0 && cyc == 2)
                check("in_ready low when full", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream result %0d", got), 64'(bus.result), 64'(vec[got].exp_result));
                $display("stream stall=%0d: out %0d result=%h at cycle %0d", stall, got, bus.result, cyc);
                got++;
                last_deq = cyc;
            end else if (bus.out_valid) begin
                held_v = 1'b1;
                held_r = bus.result;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream result count", 64'(got), 64'(n));
        if (stall == 0) check("stream last result cycle", 64'(last_deq), 64'(n + 1));
    endtask

    initial begin
        logic [31:0] tie_res, rup_res, carry_res, carry_ovf_res;
        logic        carry_ovf_flag;
`ifdef FPM_ROUND_NEAREST_EN
        tie_res = 32'h3F800002; rup_res = 32'h3F800001; carry_res = 32'h40000000;
        carry_ovf_res = 32'h7F800000; carry_ovf_flag = 1'b1;
`else
        tie_res = 32'h3F800001; rup_res = 32'h3F800000; carry_res = 32'h3FFFFFFF;
        carry_ovf_res = 32'h7F7FFFFF; carry_ovf_flag = 1'b0;
`endif
        //          sign expSum   product            sig ovf specialRes     result        ovf unf
        vec[0]  = '{0, 10'd127, 48'h400000000000, 0, 0, 32'h0,        32'h3F800000, 0, 0};
        vec[1]  = '{0, 10'd127, 48'h900000000000, 0, 0, 32'h0,        32'h40100000, 0, 0};
        vec[2]  = '{0, 10'd127, 48'h400000C00000, 0, 0, 32'h0,        tie_res,      0, 0};
        vec[3]  = '{1, 10'd127, 48'h400000000000, 0, 0, 32'h0,        32'hBF800000, 0, 0};
        vec[4]  = '{0, 10'd254, 48'h900000000000, 0, 0, 32'h0,        32'h7F800000, 1, 0};
        vec[5]  = '{0, 10'd0,   48'h400000000000, 0, 0, 32'h0,        32'h00000000, 0, 1};
        vec[6]  = '{0, 10'd127, 48'h400000600000, 0, 0, 32'h0,        rup_res,      0, 0};
        vec[7]  = '{0, 10'd127, 48'h400000400000, 0, 0, 32'h0,        32'h3F800000, 0, 0};
        vec[8]  = '{0, 10'd127, 48'h7FFFFFC00000, 0, 0, 32'h0,        carry_res,    0, 0};
        vec[9]  = '{0, 10'd254, 48'h7FFFFFC00000, 0, 0, 32'h0,        carry_ovf_res, carry_ovf_flag, 0};
        vec[10] = '{1, 10'd127, 48'h400000000000, 1, 1, 32'h0,        32'h80000000, 0, 1};
        vec[11] = '{0, 10'd127, 48'h400000000000, 1, 0, 32'hFFFFFFFF, 32'h7F800000, 1, 0};
        vec[12] = '{0, 10'd127, 48'h400000000000, 0, 1, 32'h12345678, 32'h3F800000, 0, 0};
        vec[13] = '{1, 10'h3FB, 48'h900000000000, 0, 0, 32'h0,        32'h80000000, 0, 1};
        vec[14] = '{0, 10'd1,   48'h400000000000, 0, 0, 32'h0,        32'h00800000, 0, 0};
        vec[15] = '{0, 10'h3FF, 48'h900000000000, 0, 0, 32'h0,        32'h00000000, 0, 1};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(bus.in_ready), 64'd0);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset flags", 64'({bus.outOverflow, bus.underflow}), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        for (int i = 0; i < NVEC; i++) apply_vec(i);

        run_stream(4, 0);
        run_stream(4, 3);

        // Reset with both stages holding data.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(i);
            bus.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        check("mid reset in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post reset in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("no stale result c%0d", c), 64'(bus.out_valid), 64'd0);
        end
        $display("reset sequence: out_valid=%0b after flush", bus.out_valid);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
